dma_rd_issue: RTL and testbench

// Read-request issuer that feeds the DMA data FIFO. Issues one memory read per

---
 rtl/dma_rd_issue.sv | 102 ++++++++++
 tb/tb_dma_rd_issue.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/dma_rd_issue.sv
// DMA read-request issuer: one memory read per line from a captured start address,
// throttled so outstanding reads always fit in the downstream FIFO's free space.
module dma_rd_issue #(
  parameter int unsigned ADDR_WIDTH = 64,
  parameter int unsigned SIZE_WIDTH = 32,
  parameter int unsigned FIFO_DEPTH = 512,
  localparam int unsigned PW = $clog2(FIFO_DEPTH) + 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_go,
  input  logic [ADDR_WIDTH-1:0] i_start_addr,
  input  logic [SIZE_WIDTH-1:0] i_size,
  input  logic [PW-1:0]         i_fifo_space,
  input  logic                  i_mem_rd_full,
  output logic                  o_mem_rd_en,
  output logic [ADDR_WIDTH-1:0] o_mem_rd_addr,
  input  logic                  i_mem_rd_data_valid,
  output logic [PW-1:0]         o_pending,
  output logic                  o_done
);

  typedef enum logic [1:0] {StIdle, StIssue, StDrain, StDone} state_e;

  state_e                r_state;
  state_e                w_state_next;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [SIZE_WIDTH-1:0] r_remaining;
  logic [PW-1:0]         r_pending;
  logic [PW-1:0]         w_pending_next;
  logic                  r_done;
  logic                  w_start;
  logic                  w_issue;
  logic                  w_resp;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
    end else begin
      r_state <= w_state_next;
    end
  end

  // A zero-length go passes through DRAIN (pending is already 0), so done
  // rises two cycles after go, matching the normal drain path.
  always_comb begin
    w_state_next = r_state;
    unique case (r_state)
      StIdle, StDone: begin
        if (i_go) w_state_next = (i_size != '0) ? StIssue : StDrain;
      end
      StIssue: begin
        if (w_issue && (r_remaining == SIZE_WIDTH'(1))) w_state_next = StDrain;
      end
      StDrain: begin
        if (r_pending == '0) w_state_next = StDone;
      end
      default: w_state_next = StIdle;
    endcase
  end

  always_comb begin
    w_start = ((r_state == StIdle) || (r_state == StDone)) && i_go;
    w_issue = (r_state == StIssue) && !i_mem_rd_full && (r_pending < i_fifo_space);
    o_mem_rd_en = w_issue;
  end

  // Responses with nothing outstanding (e.g. strays after reset) are dropped.
  always_comb begin
    w_resp = i_mem_rd_data_valid && (r_pending != '0);
    w_pending_next = r_pending;
    unique case ({w_issue, w_resp})
      2'b10:   w_pending_next = r_pending + PW'(1);
      2'b01:   w_pending_next = r_pending - PW'(1);
      default: w_pending_next = r_pending;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_addr      <= '0;
      r_remaining <= '0;
      r_pending   <= '0;
      r_done      <= 1'b0;
    end else begin
      if (w_start) begin
        r_addr      <= i_start_addr;
        r_remaining <= i_size;
      end else if (w_issue) begin
        r_addr      <= r_addr + ADDR_WIDTH'(1);
        r_remaining <= r_remaining - SIZE_WIDTH'(1);
      end
      r_pending <= w_pending_next;
      r_done    <= (w_state_next == StDone);
    end
  end

  assign o_mem_rd_addr = r_addr;
  assign o_pending     = r_pending;
  assign o_done        = r_done;

endmodule

// File: tb/tb_dma_rd_issue.sv
// Directed bench for dma_rd_issue: expected request addresses are queued at each go
// and popped/compared whenever the DUT strobes a read.
module tb_dma_rd_issue;

  logic        clk = 1'b0;
  logic        rst;
  logic        go;
  logic [63:0] start_addr;
  logic [31:0] size;
  logic [9:0]  fifo_space;
  logic        mem_rd_full;
  logic        mem_rd_en;
  logic [63:0] mem_rd_addr;
  logic        mem_rd_data_valid;
  logic [9:0]  pending;
  logic        done;

  int n_cmp  = 0;
  int n_fail = 0;
  int n_issue = 0;
  logic [63:0] exp_q[$];

  always #5 clk = ~clk;

  dma_rd_issue #(
    .ADDR_WIDTH(64),
    .SIZE_WIDTH(32),
    .FIFO_DEPTH(512)
  ) dut (
    .clk                (clk),
    .rst                (rst),
    .i_go               (go),
    .i_start_addr       (start_addr),
    .i_size             (size),
    .i_fifo_space       (fifo_space),
    .i_mem_rd_full      (mem_rd_full),
    .o_mem_rd_en        (mem_rd_en),
    .o_mem_rd_addr      (mem_rd_addr),
    .i_mem_rd_data_valid(mem_rd_data_valid),
    .o_pending          (pending),
    .o_done             (done)
  );

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every strobe must match the next queued address, in order.
  always @(negedge clk) begin
    if (rst === 1'b0 && mem_rd_en === 1'b1) begin
      n_issue++;
      if (exp_q.size() == 0) begin
        chk("unexpected_issue", mem_rd_addr, 64'hx);
      end else begin
        chk("issue_addr", mem_rd_addr, exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_go(input logic [63:0] a, input logic [31:0] n);
    start_addr = a;
    size = n;
    go = 1'b1;
    for (int i = 0; i < int'(n); i++) exp_q.push_back(a + 64'(i));
    tick();
    go = 1'b0;
  endtask

  task automatic respond(input int n);
    mem_rd_data_valid = 1'b1;
    repeat (n) tick();
    mem_rd_data_valid = 1'b0;
  endtask

  task automatic wait_done(input string tag);
    int k = 0;
    while (done !== 1'b1 && k < 50) begin
      tick();
      k++;
    end
    chk(tag, {63'd0, done}, 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int base;
    rst = 1'b1;
    go = 1'b0;
    start_addr = '0;
    size = '0;
    fifo_space = 10'd512;
    mem_rd_full = 1'b0;
    mem_rd_data_valid = 1'b0;
    tick();
    tick();
    chk("rst_en", {63'd0, mem_rd_en}, 64'd0);
    chk("rst_addr", mem_rd_addr, 64'd0);
    chk("rst_pending", {54'd0, pending}, 64'd0);
    chk("rst_done", {63'd0, done}, 64'd0);
    rst = 1'b0;
    tick();

    // 1: basic 4-line transfer
    base = n_issue;
    do_go(64'h100, 32'd4);
    repeat (4) tick();
    chk("t1_issues", 64'(n_issue - base), 64'd4);
    chk("t1_pending", {54'd0, pending}, 64'd4);
    chk("t1_en_idle", {63'd0, mem_rd_en}, 64'd0);
    respond(4);
    chk("t1_pending0", {54'd0, pending}, 64'd0);
    chk("t1_done_early", {63'd0, done}, 64'd0);
    tick();
    chk("t1_done", {63'd0, done}, 64'd1);

    // 2: zero-length transfer
    base = n_issue;
    do_go(64'h900, 32'd0);
    chk("t2_done_t1", {63'd0, done}, 64'd0);
    tick();
    chk("t2_done_t2", {63'd0, done}, 64'd1);
    chk("t2_pending", {54'd0, pending}, 64'd0);
    chk("t2_issues", 64'(n_issue - base), 64'd0);

    // 3: credit throttling, then concurrent issue+response
    base = n_issue;
    fifo_space = 10'd2;
    do_go(64'h2000, 32'd8);
    repeat (4) tick();
    chk("t3_stall_issues", 64'(n_issue - base), 64'd2);
    chk("t3_stall_pending", {54'd0, pending}, 64'd2);
    fifo_space = 10'd4;
    repeat (3) tick();
    chk("t3_more_issues", 64'(n_issue - base), 64'd4);
    chk("t3_more_pending", {54'd0, pending}, 64'd4);
    fifo_space = 10'd512;
    mem_rd_data_valid = 1'b1;
    tick();
    chk("t3_same_cycle", {54'd0, pending}, 64'd4);
    repeat (7) tick();
    mem_rd_data_valid = 1'b0;
    chk("t3_issues", 64'(n_issue - base), 64'd8);
    wait_done("t3_done");

    // 4: memory queue back-pressure every other cycle
    base = n_issue;
    do_go(64'h300, 32'd6);
    for (int i = 0; i < 14; i++) begin
      mem_rd_full = i[0];
      tick();
    end
    mem_rd_full = 1'b0;
    chk("t4_issues", 64'(n_issue - base), 64'd6);
    chk("t4_pending", {54'd0, pending}, 64'd6);
    respond(6);
    wait_done("t4_done");

    // 5: address wrap, go ignored mid-ISSUE
    base = n_issue;
    do_go(64'hFFFF_FFFF_FFFF_FFFE, 32'd4);
    start_addr = 64'h5555;
    size = 32'd9;
    go = 1'b1;
    tick();
    go = 1'b0;
    repeat (4) tick();
    chk("t5_issues", 64'(n_issue - base), 64'd4);
    chk("t5_addr_wrapped", mem_rd_addr, 64'd2);
    chk("t5_pending", {54'd0, pending}, 64'd4);
    respond(4);
    wait_done("t5_done");
    chk("t5_queue_empty", 64'(exp_q.size()), 64'd0);

    // 6: reset mid-transfer, stray responses, then clean restart
    fifo_space = 10'd3;
    do_go(64'h4000, 32'd8);
    repeat (5) tick();
    chk("t6_pending3", {54'd0, pending}, 64'd3);
    rst = 1'b1;
    #1;
    chk("t6_rst_pending", {54'd0, pending}, 64'd0);
    chk("t6_rst_addr", mem_rd_addr, 64'd0);
    chk("t6_rst_en", {63'd0, mem_rd_en}, 64'd0);
    exp_q.delete();
    tick();
    rst = 1'b0;
    base = n_issue;
    respond(3);
    chk("t6_stray_pending", {54'd0, pending}, 64'd0);
    chk("t6_stray_done", {63'd0, done}, 64'd0);
    chk("t6_stray_issues", 64'(n_issue - base), 64'd0);
    fifo_space = 10'd512;
    do_go(64'h50, 32'd2);
    repeat (2) tick();
    chk("t6_new_issues", 64'(n_issue - base), 64'd2);
    respond(2);
    wait_done("t6_done");
    chk("t6_queue_empty", 64'(exp_q.size()), 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
